// File: rtl/inst_fetch_if.sv
// Bus bundle between the instruction-fetch unit, the instruction ROM,
// the redirect source and the decode stage.
// Handshake: the ROM takes a request on a cycle with mem_cs=1 and mem_stall=0
// and returns mem_din before that cycle's closing edge; decode takes the
// head entry on a cycle with dec_valid=1 and dec_ready=1. Neither valid
// signal depends on its own ready/stall input.
interface inst_fetch_if;
    logic        mem_cs;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        fetch_fault;
    logic [1:0]  fsm_state;   // debug view of the fetch FSM (0 BOOT, 1 FETCH, 2 FAULT)

    modport master (
        output mem_cs, mem_addr, dec_valid, dec_inst, dec_pc, fetch_fault, fsm_state,
        input  mem_din, mem_stall, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  mem_cs, mem_addr, dec_valid, dec_inst, dec_pc, fetch_fault, fsm_state,
        output mem_din, mem_stall, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the byte PC, issues one sequential ROM
// request per cycle, buffers returned words in a small FIFO for decode and
// handles redirects (flush) and misaligned-target faults.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fifo_inst_q [BUF_DEPTH];
    logic [31:0]        fifo_pc_q   [BUF_DEPTH];
    logic [31:0]        last_inst_q, last_pc_q;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic issue;
    logic push;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(BUF_DEPTH));
    // A redirect cycle ignores decode's pop and suppresses any issue.
    assign pop   = ~fifo_empty & bus.dec_ready & ~bus.redirect_valid;
    assign issue = (state_q == ST_FETCH) & ~bus.redirect_valid & (~fifo_full | pop);
    assign push  = issue & ~bus.mem_stall;

    assign bus.mem_cs      = issue;
    assign bus.mem_addr    = {2'b00, pc_q[31:2]};
    assign bus.dec_valid   = ~fifo_empty;
    // When empty, the outputs keep showing the last head that was presented.
    assign bus.dec_inst    = fifo_empty ? last_inst_q : fifo_inst_q[rd_ptr_q];
    assign bus.dec_pc      = fifo_empty ? last_pc_q   : fifo_pc_q[rd_ptr_q];
    assign bus.fetch_fault = (state_q == ST_FAULT);
    assign bus.fsm_state   = state_q;

    // Next-state: redirect wins over everything; otherwise PC advance and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = bus.redirect_pc;
            state_d  = (bus.redirect_pc[1:0] == 2'b00) ? ST_FETCH : ST_FAULT;
        end else begin
            if (state_q == ST_BOOT) begin
                state_d = ST_FETCH;
            end
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State, PC and FIFO control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only observed through count/pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= bus.mem_din;
            fifo_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

    // Remember the presented head so the decode outputs hold it once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_inst_q <= '0;
            last_pc_q   <= '0;
        end else if (!fifo_empty) begin
            last_inst_q <= fifo_inst_q[rd_ptr_q];
            last_pc_q   <= fifo_pc_q[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a cycle table of {inputs, expected outputs} plus
// hand-written sequences for back-to-back redirects and an in-order stream
// check under a fixed stall/backpressure pattern.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ROM: word i holds 32'h1000_0000+i for i < 64, zero beyond.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd64) return 32'h1000_0000 + a;
    return 32'h0;
  endfunction

  assign bus.mem_din = rom_word(bus.mem_addr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        ready;
    logic        cs;
    logic [31:0] addr;
    logic        dv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ff;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] exp_q[$];

  function automatic vec_t mk(input logic r, input logic s, input logic rv,
                              input logic [31:0] rpc, input logic rdy,
                              input logic cs, input logic [31:0] addr, input logic dv,
                              input logic [31:0] inst, input logic [31:0] pc,
                              input logic ff);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.ready = rdy;
    v.cs = cs; v.addr = addr; v.dv = dv; v.inst = inst; v.pc = pc; v.ff = ff;
    return v;
  endfunction

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic drive(input logic r, input logic s, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst = r;
    bus.mem_stall = s;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.dec_ready = rdy;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int pops;
    logic [63:0] e;
    logic s, rdy;

    rst = 1'b1;
    bus.mem_stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.dec_ready = 1'b1;

    // ---------------- cycle table ----------------
    //                  rst st rv rpc           rdy cs addr          dv inst           pc            ff
    vecs.push_back(mk(1, 0, 0, 32'h0,         1,  0, 32'h0,        0, 32'h0,         32'h0,        0)); // v0 reset
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 32'h0,        0, 32'h0,         32'h0,        0)); // v1 BOOT
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h0,        0, 32'h0,         32'h0,        0)); // v2 first issue
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h1,        1, 32'h1000_0000, 32'h0,        0)); // v3
    vecs.push_back(mk(0, 1, 0, 32'h0,         1,  1, 32'h2,        1, 32'h1000_0001, 32'h4,        0)); // v4 stall
    vecs.push_back(mk(0, 1, 0, 32'h0,         1,  1, 32'h2,        0, 32'h1000_0001, 32'h4,        0)); // v5 stall
    vecs.push_back(mk(0, 1, 0, 32'h0,         1,  1, 32'h2,        0, 32'h1000_0001, 32'h4,        0)); // v6 stall
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h2,        0, 32'h1000_0001, 32'h4,        0)); // v7 retry taken
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h3,        1, 32'h1000_0002, 32'h8,        0)); // v8
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,  1, 32'h4,        1, 32'h1000_0003, 32'hC,        0)); // v9 ready low
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,  0, 32'h5,        1, 32'h1000_0003, 32'hC,        0)); // v10 full
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,  0, 32'h5,        1, 32'h1000_0003, 32'hC,        0)); // v11
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,  0, 32'h5,        1, 32'h1000_0003, 32'hC,        0)); // v12
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,  0, 32'h5,        1, 32'h1000_0003, 32'hC,        0)); // v13
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h5,        1, 32'h1000_0003, 32'hC,        0)); // v14 full+pop
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h6,        1, 32'h1000_0004, 32'h10,       0)); // v15
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,  0, 32'h7,        1, 32'h1000_0005, 32'h14,       0)); // v16 full
    vecs.push_back(mk(0, 0, 1, 32'h20,        1,  0, 32'h7,        1, 32'h1000_0005, 32'h14,       0)); // v17 redirect
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h8,        0, 32'h1000_0005, 32'h14,       0)); // v18 flushed
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h9,        1, 32'h1000_0008, 32'h20,       0)); // v19 target
    vecs.push_back(mk(0, 0, 1, 32'h22,        1,  0, 32'hA,        1, 32'h1000_0009, 32'h24,       0)); // v20 misaligned
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 32'h8,        0, 32'h1000_0009, 32'h24,       1)); // v21 FAULT
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 32'h8,        0, 32'h1000_0009, 32'h24,       1)); // v22
    vecs.push_back(mk(0, 0, 1, 32'h40,        1,  0, 32'h8,        0, 32'h1000_0009, 32'h24,       1)); // v23 recover
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h10,       0, 32'h1000_0009, 32'h24,       0)); // v24
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h11,       1, 32'h1000_0010, 32'h40,       0)); // v25
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFF8, 1,  0, 32'h12,       1, 32'h1000_0011, 32'h44,       0)); // v26 to top
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h3FFF_FFFE,0, 32'h1000_0011, 32'h44,       0)); // v27
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h3FFF_FFFF,1, 32'h0,         32'hFFFF_FFF8,0)); // v28
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h0,        1, 32'h0,         32'hFFFF_FFFC,0)); // v29 wrap
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h1,        1, 32'h1000_0000, 32'h0,        0)); // v30
    vecs.push_back(mk(0, 0, 0, 32'h0,         0,  1, 32'h2,        1, 32'h1000_0001, 32'h4,        0)); // v31 fill
    vecs.push_back(mk(0, 1, 0, 32'h0,         0,  0, 32'h3,        1, 32'h1000_0001, 32'h4,        0)); // v32 full+stall
    vecs.push_back(mk(1, 1, 0, 32'h0,         0,  0, 32'h0,        0, 32'h0,         32'h0,        0)); // v33 async rst
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 32'h0,        0, 32'h0,         32'h0,        0)); // v34 BOOT
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h0,        0, 32'h0,         32'h0,        0)); // v35
    vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h1,        1, 32'h1000_0000, 32'h0,        0)); // v36

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ready);
      chk($sformatf("v%0d mem_cs", i),      {31'h0, bus.mem_cs},      {31'h0, vecs[i].cs});
      chk($sformatf("v%0d mem_addr", i),    bus.mem_addr,             vecs[i].addr);
      chk($sformatf("v%0d dec_valid", i),   {31'h0, bus.dec_valid},   {31'h0, vecs[i].dv});
      chk($sformatf("v%0d dec_inst", i),    bus.dec_inst,             vecs[i].inst);
      chk($sformatf("v%0d dec_pc", i),      bus.dec_pc,               vecs[i].pc);
      chk($sformatf("v%0d fetch_fault", i), {31'h0, bus.fetch_fault}, {31'h0, vecs[i].ff});
    end

    // ---------------- back-to-back redirects: last one wins ----------------
    drive(0, 0, 1, 32'h10, 1);
    chk("bb1 mem_cs", {31'h0, bus.mem_cs}, 32'h0);
    drive(0, 0, 1, 32'h30, 1);
    chk("bb2 dec_valid", {31'h0, bus.dec_valid}, 32'h0);
    chk("bb2 mem_cs", {31'h0, bus.mem_cs}, 32'h0);
    drive(0, 0, 0, 32'h0, 1);
    chk("bb3 mem_addr", bus.mem_addr, 32'hC);
    chk("bb3 dec_valid", {31'h0, bus.dec_valid}, 32'h0);
    drive(0, 0, 0, 32'h0, 1);
    chk("bb4 dec_pc", bus.dec_pc, 32'h30);
    chk("bb4 dec_inst", bus.dec_inst, 32'h1000_000C);
    // misaligned immediately followed by aligned
    drive(0, 0, 1, 32'h31, 1);
    drive(0, 0, 1, 32'h50, 1);
    chk("mf1 fetch_fault", {31'h0, bus.fetch_fault}, 32'h1);
    drive(0, 0, 0, 32'h0, 1);
    chk("mf2 fetch_fault", {31'h0, bus.fetch_fault}, 32'h0);
    chk("mf2 mem_addr", bus.mem_addr, 32'h14);
    chk("mf2 mem_cs", {31'h0, bus.mem_cs}, 32'h1);
    drive(0, 0, 0, 32'h0, 1);
    chk("mf3 dec_pc", bus.dec_pc, 32'h50);
    chk("mf3 dec_inst", bus.dec_inst, 32'h1000_0014);

    // ---------------- in-order stream under stall/backpressure ----------------
    drive(0, 0, 1, 32'h80, 1);
    for (int k = 0; k < 45; k++) begin
      exp_q.push_back({rom_word(32'd32 + 32'(k)), 32'h80 + 32'(4 * k)});
    end
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      s = ((i % 5) == 2) || ((i % 7) == 3);
      rdy = ((i % 3) != 1);
      drive(0, s, 0, 32'h0, rdy);
      if (bus.dec_valid && rdy) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk($sformatf("stream pop%0d extra", pops), 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream pop%0d inst", pops), bus.dec_inst, e[63:32]);
          chk($sformatf("stream pop%0d pc", pops), bus.dec_pc, e[31:0]);
        end
      end
    end
    chk("stream pop count ok", {31'h0, (pops >= 10)}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
